uart_loader: RTL and testbench

- UART-to-memory-bus bridge; the host-side counterpart of the CPU on the system bus.
- Decodes byte commands from the uart receiver and issues RAM/IO reads and writes as bus initiator.
- Replies through the uart transmitter and holds the CPU in reset until told to run.
- Sits between the uart block and the mmu address/data mux, clocked with the uart.

---
 rtl/uart_loader.sv | 158 +++++++++++++++
 tb/tb_uart_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// UART command bridge: decodes W/R/G/H byte commands from the uart receiver,
// drives the memory bus as initiator and replies through the uart transmitter.
module uart_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_done,
    output logic [15:0] bus_addr,
    output logic        bus_we,
    output logic [7:0]  bus_do,
    input  logic [7:0]  bus_di,
    output logic        bus_grant,
    output logic        cpu_hold
);

    localparam logic [7:0]  CMD_W = 8'h57;
    localparam logic [7:0]  CMD_R = 8'h52;
    localparam logic [7:0]  CMD_G = 8'h47;
    localparam logic [7:0]  CMD_H = 8'h48;
    localparam logic [31:0] TMO   = 32'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN, S_WDATA,
        S_WSTROBE, S_RADDR, S_RLATCH, S_TXSEND, S_TXWAIT
    } state_t;

    state_t      r_state, w_next;
    logic [15:0] r_ptr;
    logic [8:0]  r_cnt;
    logic        r_cmd_w;
    logic        r_rd_mode;
    logic [31:0] r_tmo;
    logic [7:0]  r_tx_data;
    logic [15:0] r_bus_addr;
    logic [7:0]  r_bus_do;
    logic        r_cpu_hold;
    logic        w_timed;
    logic        w_tmo_hit;
    logic        w_last;

    assign w_timed   = (r_state == S_ADDR_HI) || (r_state == S_ADDR_LO) ||
                       (r_state == S_LEN)     || (r_state == S_WDATA);
    assign w_tmo_hit = w_timed && !rx_done && (r_tmo >= TMO);
    assign w_last    = (r_cnt == 9'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:
                if (rx_done)
                    w_next = (rx_data == CMD_W || rx_data == CMD_R) ? S_ADDR_HI : S_TXSEND;
            S_ADDR_HI: if (rx_done) w_next = S_ADDR_LO; else if (w_tmo_hit) w_next = S_IDLE;
            S_ADDR_LO: if (rx_done) w_next = S_LEN;     else if (w_tmo_hit) w_next = S_IDLE;
            S_LEN:
                if (rx_done)        w_next = r_cmd_w ? S_WDATA : S_RADDR;
                else if (w_tmo_hit) w_next = S_IDLE;
            S_WDATA:   if (rx_done) w_next = S_WSTROBE; else if (w_tmo_hit) w_next = S_IDLE;
            S_WSTROBE: w_next = w_last ? S_TXSEND : S_WDATA;
            S_RADDR:   w_next = S_RLATCH;
            S_RLATCH:  w_next = S_TXSEND;
            S_TXSEND:  w_next = S_TXWAIT;
            S_TXWAIT:
                if (tx_done) w_next = (r_rd_mode && !w_last) ? S_RADDR : S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Strobes decode straight from state so reset drops them without waiting for a clock.
    always_comb begin
        bus_we    = (r_state == S_WSTROBE);
        tx_wr     = (r_state == S_TXSEND);
        bus_grant = (r_state == S_WDATA) || (r_state == S_WSTROBE) ||
                    (r_state == S_RADDR) || (r_state == S_RLATCH) ||
                    (((r_state == S_TXSEND) || (r_state == S_TXWAIT)) && r_rd_mode && !w_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_cmd_w    <= 1'b0;
            r_rd_mode  <= 1'b0;
            r_tmo      <= '0;
            r_tx_data  <= '0;
            r_bus_addr <= '0;
            r_bus_do   <= '0;
            r_cpu_hold <= 1'b1;
        end else begin
            r_tmo <= (w_timed && !rx_done) ? r_tmo + 32'd1 : '0;
            case (r_state)
                S_IDLE:
                    if (rx_done) begin
                        r_cmd_w   <= (rx_data == CMD_W);
                        r_rd_mode <= 1'b0;
                        if (rx_data == CMD_G) begin
                            r_cpu_hold <= 1'b0;
                            r_tx_data  <= ACK_BYTE;
                        end else if (rx_data == CMD_H) begin
                            r_cpu_hold <= 1'b1;
                            r_tx_data  <= ACK_BYTE;
                        end else if (rx_data != CMD_W && rx_data != CMD_R) begin
                            r_tx_data  <= NAK_BYTE;
                        end
                    end
                S_ADDR_HI: if (rx_done) r_ptr[15:8] <= rx_data;
                S_ADDR_LO: if (rx_done) r_ptr[7:0]  <= rx_data;
                S_LEN:
                    if (rx_done) begin
                        r_cnt <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        if (!r_cmd_w) begin
                            r_bus_addr <= r_ptr;
                            r_rd_mode  <= 1'b1;
                        end
                    end
                S_WDATA:
                    if (rx_done) begin
                        r_bus_addr <= r_ptr;
                        r_bus_do   <= rx_data;
                    end
                S_WSTROBE: begin
                    r_ptr <= r_ptr + 16'd1;
                    r_cnt <= r_cnt - 9'd1;
                    if (w_last) r_tx_data <= ACK_BYTE;
                end
                S_RLATCH: r_tx_data <= bus_di;
                S_TXWAIT:
                    if (tx_done && r_rd_mode) begin
                        if (w_last) begin
                            r_rd_mode <= 1'b0;
                        end else begin
                            r_ptr      <= r_ptr + 16'd1;
                            r_cnt      <= r_cnt - 9'd1;
                            r_bus_addr <= r_ptr + 16'd1;
                        end
                    end
                default: ;
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign bus_addr = r_bus_addr;
    assign bus_do   = r_bus_do;
    assign cpu_hold = r_cpu_hold;

endmodule

// File: tb/tb_uart_loader.sv
// Directed plus randomized bench for uart_loader: a sync RAM and a uart tx responder
// surround the DUT, and expected bus writes / tx bytes come from a command-level model.
module tb_uart_loader;

    localparam int unsigned TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_done = 1'b0;
    logic [15:0] bus_addr;
    logic        bus_we;
    logic [7:0]  bus_do;
    logic [7:0]  bus_di;
    logic        bus_grant;
    logic        cpu_hold;

    always #5 clk = ~clk;

    uart_loader #(.TIMEOUT_CYCLES(TMO), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_done(tx_done),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_do(bus_do), .bus_di(bus_di),
        .bus_grant(bus_grant), .cpu_hold(cpu_hold)
    );

    // Synchronous RAM on the bus
    logic [7:0] ram [65536];
    logic [7:0] ram_q;
    always @(posedge clk) begin
        if (bus_we) ram[bus_addr] <= bus_do;
        ram_q <= ram[bus_addr];
    end
    assign bus_di = ram_q;

    // Observed traffic and uart transmitter responder
    logic [23:0] wq[$];
    logic [7:0]  tq[$];
    int          viol = 0;
    int          tx_cd = 0;
    bit          tx_busy = 1'b0;
    bit          prev_we = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            tx_done = 1'b0;
            tx_cd   = 0;
            tx_busy = 1'b0;
            prev_we = 1'b0;
        end else begin
            tx_done = 1'b0;
            if (tx_cd > 0) begin
                tx_cd--;
                if (tx_cd == 0) begin
                    tx_done = 1'b1;
                    tx_busy = 1'b0;
                end
            end
            if (tx_wr) begin
                if (tx_busy) viol++;
                tq.push_back(tx_data);
                tx_busy = 1'b1;
                tx_cd   = int'($urandom_range(3, 8));
            end
            if (bus_we) begin
                if (!bus_grant || prev_we) viol++;
                wq.push_back({bus_addr, bus_do});
            end
            prev_we = bus_we;
        end
    end

    // Reference model state
    logic [7:0]  ref_mem [65536];
    logic [23:0] exp_wq[$];
    logic [7:0]  exp_tq[$];
    logic        ref_hold;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        repeat ($urandom_range(2, 5)) @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic wait_tx(input string tag);
        int k = 0;
        while ((tq.size() < exp_tq.size() || tx_busy) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_in_time"}, 32'(k < 4000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_nwrites"}, 32'(wq.size()), 32'(exp_wq.size()));
        for (int i = 0; i < wq.size() && i < exp_wq.size(); i++)
            chk($sformatf("%s_write%0d", tag, i), 32'(wq[i]), 32'(exp_wq[i]));
        chk({tag, "_ntx"}, 32'(tq.size()), 32'(exp_tq.size()));
        for (int i = 0; i < tq.size() && i < exp_tq.size(); i++)
            chk($sformatf("%s_tx%0d", tag, i), 32'(tq[i]), 32'(exp_tq[i]));
        chk({tag, "_protocol"}, 32'(viol), 32'd0);
        wq.delete(); tq.delete(); exp_wq.delete(); exp_tq.delete();
        viol = 0;
    endtask

    task automatic model_write(input logic [15:0] a, input logic [7:0] d);
        exp_wq.push_back({a, d});
        ref_mem[a] = d;
    endtask

    task automatic cmd_write(input string tag, input logic [15:0] a, input logic [7:0] d[$]);
        send(8'h57); send(a[15:8]); send(a[7:0]); send(8'(d.size()));
        chk({tag, "_grant_hdr"}, 32'(bus_grant), 32'd1);
        for (int i = 0; i < d.size(); i++) begin
            send(d[i]);
            model_write(a + 16'(i), d[i]);
        end
        exp_tq.push_back(8'h06);
        wait_tx(tag);
        chk({tag, "_grant_end"}, 32'(bus_grant), 32'd0);
        compare(tag);
    endtask

    task automatic cmd_read(input string tag, input logic [15:0] a, input int n);
        send(8'h52); send(a[15:8]); send(a[7:0]); send(8'(n));
        for (int i = 0; i < n; i++) exp_tq.push_back(ref_mem[a + 16'(i)]);
        wait_tx(tag);
        chk({tag, "_grant_end"}, 32'(bus_grant), 32'd0);
        compare(tag);
    endtask

    task automatic cmd_simple(input string tag, input logic [7:0] b);
        send(b);
        if (b == 8'h47)      begin ref_hold = 1'b0; exp_tq.push_back(8'h06); end
        else if (b == 8'h48) begin ref_hold = 1'b1; exp_tq.push_back(8'h06); end
        else                 exp_tq.push_back(8'h15);
        wait_tx(tag);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'(ref_hold));
        compare(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx_data"},   32'(tx_data),   32'd0);
        chk({tag, "_tx_wr"},     32'(tx_wr),     32'd0);
        chk({tag, "_bus_addr"},  32'(bus_addr),  32'd0);
        chk({tag, "_bus_we"},    32'(bus_we),    32'd0);
        chk({tag, "_bus_do"},    32'(bus_do),    32'd0);
        chk({tag, "_bus_grant"}, 32'(bus_grant), 32'd0);
        chk({tag, "_cpu_hold"},  32'(cpu_hold),  32'd1);
    endtask

    initial begin
        logic [7:0]  d[$];
        logic [15:0] a;
        int          n;

        rst = 1'b1; rx_done = 1'b0; rx_data = '0; ref_hold = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        d = '{8'hAA, 8'hBB, 8'hCC};
        cmd_write("w100", 16'h0100, d);
        cmd_read("r100", 16'h0100, 3);

        d = '{8'h11, 8'h22};
        cmd_write("wwrap", 16'hFFFF, d);
        cmd_read("rwrap", 16'hFFFF, 2);

        chk("hold_after_reset", 32'(cpu_hold), 32'd1);
        cmd_simple("go", 8'h47);
        cmd_simple("halt", 8'h48);
        cmd_simple("nak", 8'h5A);
        cmd_simple("go2", 8'h47);
        cmd_simple("nak2", 8'h00);

        d.delete();
        for (int i = 0; i < 256; i++) d.push_back(8'($urandom));
        cmd_write("w256", 16'h0200, d);
        cmd_read("r256", 16'h0200, 256);

        // Timeout mid-write: one byte lands, then silence
        send(8'h57); send(8'h03); send(8'h00); send(8'h04); send(8'h11);
        model_write(16'h0300, 8'h11);
        repeat (TMO + 10) @(negedge clk);
        chk("tmo_grant", 32'(bus_grant), 32'd0);
        compare("tmo");
        cmd_simple("tmo_go", 8'h47);
        cmd_read("tmo_rd", 16'h0300, 1);

        for (int it = 0; it < 6; it++) begin
            a = 16'($urandom);
            n = int'($urandom_range(1, 12));
            d.delete();
            for (int i = 0; i < n; i++) d.push_back(8'($urandom));
            cmd_write($sformatf("rw%0d", it), a, d);
            cmd_read($sformatf("rr%0d", it), a + 16'($urandom_range(0, n - 1)),
                     int'($urandom_range(1, n)));
        end

        // Asynchronous reset in WDATA of a 4-byte write
        cmd_simple("pre_rst_go", 8'h47);
        send(8'h57); send(8'h04); send(8'h00); send(8'h04); send(8'h5C); send(8'hA3);
        model_write(16'h0400, 8'h5C);
        model_write(16'h0401, 8'hA3);
        @(negedge clk);
        chk("mid_grant", 32'(bus_grant), 32'd1);
        chk("mid_bus_do", 32'(bus_do), 32'hA3);
        #2 rst = 1'b1;
        #1 chk_reset_vals("async_rst");
        ref_hold = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compare("rst_partial");
        repeat (2) @(negedge clk);
        cmd_read("post_rst_rd", 16'h0400, 2);
        cmd_simple("post_rst_halt", 8'h48);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
